// File: rtl/resp_out_fifo.sv
// Response output buffer: circular FIFO between execution side and requester,
// with full-drop accounting and a sticky stall detector on the output.
module resp_out_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_resp,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_full,
  output logic              out_valid,
  output logic [1:0]        out_resp,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [7:0]        drop_cnt,
  output logic              stall_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(STALL_MAX + 1);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] StallCnt = BW'(STALL_MAX);

  typedef enum logic [1:0] {StIdle = 2'd0, StSend = 2'd1, StStall = 2'd2} state_e;

  logic [1:0]        resp_mem [DEPTH];
  logic [ID_W-1:0]   id_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [7:0]    drop_q;
  logic          stall_q, stall_d;
  state_e        state_q, state_d;

  logic offer, push, pop, drop;

  assign offer = in_valid && (in_resp != 2'd0);
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign push  = offer && ((count_q < FullCnt) || pop);
  assign drop  = offer && (count_q == FullCnt) && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    blk_d = '0;
    if (out_valid && !out_ready) begin
      blk_d = (blk_q == StallCnt) ? blk_q : blk_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      blk_q    <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        resp_mem[i] <= '0;
        id_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        resp_mem[wr_ptr_q] <= in_resp;
        id_mem[wr_ptr_q]   <= in_id;
        data_mem[wr_ptr_q] <= in_data;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      blk_q   <= blk_d;
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Control FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (count_d != '0) state_d = StSend;
      end
      StSend: begin
        if (count_d == '0)          state_d = StIdle;
        else if (blk_d == StallCnt) state_d = StStall;
      end
      StStall: begin
        if (pop) state_d = (count_d == '0) ? StIdle : StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    stall_d = stall_q | (state_d == StStall);
  end

  assign in_full   = (count_q == FullCnt);
  assign out_valid = (count_q != '0);
  assign out_resp  = out_valid ? resp_mem[rd_ptr_q] : '0;
  assign out_id    = out_valid ? id_mem[rd_ptr_q]   : '0;
  assign out_data  = out_valid ? data_mem[rd_ptr_q] : '0;
  assign drop_cnt  = drop_q;
  assign stall_err = stall_q;

endmodule

// File: tb/tb_resp_out_fifo.sv
// Directed bench for resp_out_fifo; every check is an immediate assertion
// against hand-computed values.
module tb_resp_out_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_resp;
  logic [1:0]  in_id;
  logic [31:0] in_data;
  logic        in_full;
  logic        out_valid;
  logic [1:0]  out_resp;
  logic [1:0]  out_id;
  logic [31:0] out_data;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic        stall_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  resp_out_fifo #(
    .DEPTH(4), .ID_W(2), .DATA_W(32), .STALL_MAX(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_resp   (in_resp),
    .in_id     (in_id),
    .in_data   (in_data),
    .in_full   (in_full),
    .out_valid (out_valid),
    .out_resp  (out_resp),
    .out_id    (out_id),
    .out_data  (out_data),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .stall_err (stall_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [1:0] r, input logic [1:0] id, input logic [31:0] d);
    in_valid = 1'b1;
    in_resp  = r;
    in_id    = id;
    in_data  = d;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_resp  = 2'd0;
    in_id    = 2'd0;
    in_data  = 32'd0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_resp"},  64'(out_resp),  64'd0);
    chk({tag, "_id"},    64'(out_id),    64'd0);
    chk({tag, "_data"},  64'(out_data),  64'd0);
  endtask

  task automatic chk_head(input string tag, input logic [1:0] r, input logic [1:0] id,
                          input logic [31:0] d);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_resp"},  64'(out_resp),  64'(r));
    chk({tag, "_id"},    64'(out_id),    64'(id));
    chk({tag, "_data"},  64'(out_data),  64'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_in();
    step();
    step();
    // reset state
    chk_empty("rst");
    chk("rst_full", 64'(in_full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_stall", 64'(stall_err), 64'd0);
    chk("rst_fsm", 64'(dut.state_q), 64'd0);
    rst = 1'b0;

    // single push, latency 1, hold while not ready
    offer(2'd1, 2'd2, 32'h5);
    chk("nobypass_valid", 64'(out_valid), 64'd0);
    step();
    idle_in();
    chk_head("p1", 2'd1, 2'd2, 32'h5);
    chk("p1_fsm", 64'(dut.state_q), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head("p1_hold", 2'd1, 2'd2, 32'h5);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_empty("p1_pop");
    chk("p1_pop_fsm", 64'(dut.state_q), 64'd0);

    // in_resp==0 offer is ignored
    offer(2'd0, 2'd3, 32'h7);
    step();
    idle_in();
    chk_empty("none");
    chk("none_drop", 64'(drop_cnt), 64'd0);

    // fill to full, drop one, drain in order
    for (int i = 0; i < 4; i++) begin
      offer(2'd1, 2'(i), 32'h10 + 32'(i));
      step();
    end
    chk("fill_full", 64'(in_full), 64'd1);
    offer(2'd2, 2'd1, 32'hDEAD);
    step();
    idle_in();
    chk("drop1", 64'(drop_cnt), 64'd1);
    chk("drop_full", 64'(in_full), 64'd1);
    out_ready = 1'b1;
    chk("full_ready_indep", 64'(in_full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", 2'd1, 2'(i), 32'h10 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk_empty("drained");
    chk("drained_full", 64'(in_full), 64'd0);

    // simultaneous push and pop at full
    for (int i = 0; i < 4; i++) begin
      offer(2'd1, 2'(i), 32'h20 + 32'(i));
      step();
    end
    offer(2'd3, 2'd2, 32'h99);
    out_ready = 1'b1;
    step();
    idle_in();
    chk("pp_full", 64'(in_full), 64'd1);
    chk("pp_drop", 64'(drop_cnt), 64'd1);
    chk_head("pp_h1", 2'd1, 2'd1, 32'h21);
    step();
    chk("pp_notfull", 64'(in_full), 64'd0);
    chk_head("pp_h2", 2'd1, 2'd2, 32'h22);
    step();
    chk_head("pp_h3", 2'd1, 2'd3, 32'h23);
    step();
    chk_head("pp_new", 2'd3, 2'd2, 32'h99);
    step();
    out_ready = 1'b0;
    chk_empty("pp_end");

    // stall detection after 15 blocked cycles
    offer(2'd3, 2'd1, 32'hAB);
    step();
    idle_in();
    for (int i = 0; i < 14; i++) step();
    chk("stall14_err", 64'(stall_err), 64'd0);
    chk("stall14_fsm", 64'(dut.state_q), 64'd1);
    step();
    chk("stall15_err", 64'(stall_err), 64'd1);
    chk("stall15_fsm", 64'(dut.state_q), 64'd2);
    chk_head("stall_head", 2'd3, 2'd1, 32'hAB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_pop_fsm", 64'(dut.state_q), 64'd0);
    chk("stall_sticky", 64'(stall_err), 64'd1);
    chk_empty("stall_pop");
    step();
    step();
    chk("stall_sticky2", 64'(stall_err), 64'd1);

    // reset mid-operation discards contents
    for (int i = 1; i < 4; i++) begin
      offer(2'd1, 2'(i), 32'h30 + 32'(i));
      step();
    end
    idle_in();
    chk_head("pre_rst", 2'd1, 2'd1, 32'h31);
    do_reset();
    chk_empty("mid_rst");
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_stall", 64'(stall_err), 64'd0);
    chk("mid_rst_full", 64'(in_full), 64'd0);
    offer(2'd1, 2'd0, 32'h77);
    step();
    idle_in();
    chk_head("post_rst", 2'd1, 2'd0, 32'h77);
    chk("post_rst_entry0", 64'(dut.data_mem[0]), 64'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_empty("post_rst_alone");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resp_out_fifo.md
RESP_OUT_FIFO -- requirements
Module: resp_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of response entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter ID_W, default 2, meaning the request/response tag width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the response data width.
REQ-004 SHALL have parameter STALL_MAX, default 15, meaning the number of consecutive blocked cycles before a stall error is flagged.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  a response from the execution side is offered this cycle.
REQ-008 in_resp  in  2  response code: 0 = none, 1 = success, 2 = overflow/underflow, 3 = invalid command.
REQ-009 in_id  in  ID_W  tag of the originating request.
REQ-010 in_data  in  DATA_W  result data.
REQ-011 in_full  out  1  buffer full (count == DEPTH).
REQ-012 out_valid  out  1  a head response is presented.
REQ-013 out_resp / out_id / out_data  out  2 / ID_W / DATA_W  head response fields.
REQ-014 out_ready  in  1  the requester accepts the presented response.
REQ-015 drop_cnt  out  8  number of offered responses lost because the buffer was full.
REQ-016 stall_err  out  1  sticky flag: the output was blocked STALL_MAX consecutive cycles.

Function
REQ-017 A push SHALL occur when in_valid=1, in_resp!=0, and either count<DEPTH or a pop occurs in the same cycle.
REQ-018 When in_valid=1 and in_resp==0, the offer SHALL be ignored; it is not stored and not counted.
REQ-019 A pop SHALL occur when out_valid && out_ready.
REQ-020 Storage SHALL be a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; this applies at full and at empty+1.
REQ-022 There SHALL be no bypass: an entry pushed while empty SHALL appear on out_valid/out_* on the next cycle (latency 1).
REQ-023 out_valid SHALL equal (count != 0), and out_* SHALL be the entry at rd_ptr.
REQ-024 When out_valid=0, out_resp, out_id and out_data SHALL be driven to 0.
REQ-025 While out_valid=1 and out_ready=0, out_* SHALL remain stable.
REQ-026 An offer with in_resp!=0 that is rejected because the buffer is full with no pop SHALL increment drop_cnt by 1; drop_cnt SHALL saturate at 255.
REQ-027 A control FSM SHALL have three states: IDLE (count==0), SEND (out_valid, not yet stalled) and STALL.
REQ-028 FSM transitions:
- IDLE->SEND when count becomes nonzero.
- SEND->IDLE when count becomes 0.
- SEND->STALL when the blocked counter reaches STALL_MAX.
- STALL->SEND on a pop with count remaining >0.
- STALL->IDLE on a pop leaving count 0.
REQ-029 The blocked counter SHALL increment each cycle with out_valid=1 and out_ready=0, and clear on any pop or when out_valid=0.
REQ-030 The blocked counter SHALL saturate at STALL_MAX.
REQ-031 stall_err SHALL set on entry to STALL and remain 1 until reset.
REQ-032 in_full SHALL be combinational from count and SHALL NOT depend on out_ready.

Reset
REQ-033 On rst=1 at a clock edge, the following SHALL clear to 0: pointers, count, blocked counter, drop_cnt, stall_err, and all storage entries; the FSM SHALL go to IDLE.
REQ-034 During and immediately after reset, out_valid=0, out_*=0 and in_full=0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries with no pop observed; the first push after reset SHALL land in entry 0.

Verification
REQ-036 Push 1 (in_resp=1, id=2, data=0x0000_0005) into an empty buffer with out_ready=0 -> out_valid=1 the next cycle, out_id=2, out_data=5; fields held while ready stays low.
REQ-037 Push 4 entries (ids 0..3) with out_ready=0, then offer id=1 with in_resp=2 -> in_full=1, drop_cnt=1; then raise out_ready -> ids 0,1,2,3 emerge in order on 4 consecutive cycles, then out_valid=0 and outputs are 0.
REQ-038 At full, push and pop on the same cycle -> count stays 4, in_full stays 1, drop_cnt unchanged, new entry emerges after the previous three.
REQ-039 Offer in_valid=1, in_resp=0 -> no state change, out_valid stays 0, drop_cnt=0.
REQ-040 Hold out_ready=0 with one entry for 15 cycles -> stall_err=1 and FSM=STALL; pop it -> FSM=IDLE, stall_err remains 1 until rst.
REQ-041 Fill 3 entries, assert rst for 1 cycle -> out_valid=0, drop_cnt=0, stall_err=0; the next push appears alone at the head.
